// File: rtl/des_key_schedule_seq_pkg.sv
// Shared DES key-schedule definitions: widths, permutation tables, shift table, FSM state.
package des_key_schedule_seq_pkg;

  localparam int unsigned KEY_W  = 64;
  localparam int unsigned PC1_W  = 56;
  localparam int unsigned HALF_W = 28;
  localparam int unsigned RK_W   = 48;
  localparam int unsigned IDX_W  = 4;

  // PC-1: output DES bit i+1 takes key DES bit PC1_TBL[i] (1-based, bit 1 = MSB)
  localparam int unsigned PC1_TBL [PC1_W] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };

  // PC-2: output DES bit i+1 takes C/D DES bit PC2_TBL[i]
  localparam int unsigned PC2_TBL [RK_W] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };

  // Per-round rotation amount
  localparam logic [1:0] SHIFT_TBL [16] = '{
    2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
    2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
  };

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // C/D register pair, C in the upper half
  typedef struct packed {
    logic [HALF_W-1:0] c;
    logic [HALF_W-1:0] d;
  } cd_t;

  // True when the given round rotates by two positions
  function automatic logic shift_two(input logic [IDX_W-1:0] idx);
    return SHIFT_TBL[idx] == 2'd2;
  endfunction

endpackage

// File: rtl/p_box_56_48.sv
// PC-2 permutation: 56-bit C/D to 48-bit round key.
module p_box_56_48
  import des_key_schedule_seq_pkg::*;
(
  input  logic [PC1_W-1:0] din,
  output logic [RK_W-1:0]  dout
);

  // C/D bits 9,18,22,25,35,38,43,54 are not selected by PC-2
  logic unused_dropped;
  assign unused_dropped = ^{din[47], din[38], din[34], din[31],
                            din[21], din[18], din[13], din[2]};

  // Pure wiring, DES bit n lives at vector position width-n
  for (genvar i = 0; i < RK_W; i++) begin : g_map
    assign dout[RK_W-1-i] = din[PC1_W - PC2_TBL[i]];
  end

endmodule

// File: rtl/p_box_64_56.sv
// PC-1 permutation: 64-bit key to 56-bit C/D, parity bits dropped.
module p_box_64_56
  import des_key_schedule_seq_pkg::*;
(
  input  logic [KEY_W-1:0] din,
  output logic [PC1_W-1:0] dout
);

  // Parity bits (DES bits 8,16,..,64) do not enter the schedule
  logic unused_parity;
  assign unused_parity = ^{din[56], din[48], din[40], din[32],
                           din[24], din[16], din[8],  din[0]};

  // Pure wiring, DES bit n lives at vector position width-n
  for (genvar i = 0; i < PC1_W; i++) begin : g_map
    assign dout[PC1_W-1-i] = din[KEY_W - PC1_TBL[i]];
  end

endmodule

// File: rtl/des_key_schedule_seq.sv
// Iterative DES key-schedule sequencer: one 48-bit round key per handshake.
module des_key_schedule_seq
  import des_key_schedule_seq_pkg::*;
#(
  parameter bit CLEAR_ON_DONE = 1'b1
)(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              key_valid,
  output logic              key_ready,
  input  logic [KEY_W-1:0]  key_in,
  input  logic              decrypt,
  output logic              rk_valid,
  input  logic              rk_ready,
  output logic [RK_W-1:0]   round_key,
  output logic [IDX_W-1:0]  round_idx,
  output logic              last_round
);

  // Rotate a 28-bit half by 1 or 2 positions; left moves toward DES bit 1
  function automatic logic [HALF_W-1:0] rot_half(input logic [HALF_W-1:0] x,
                                                 input logic left,
                                                 input logic two);
    if (left) return two ? {x[HALF_W-3:0], x[HALF_W-1:HALF_W-2]}
                         : {x[HALF_W-2:0], x[HALF_W-1]};
    else      return two ? {x[1:0], x[HALF_W-1:2]}
                         : {x[0], x[HALF_W-1:1]};
  endfunction

  state_e            state;
  cd_t               cd;
  logic              mode;
  logic [PC1_W-1:0]  pc1_c;
  cd_t               load_raw_c;
  cd_t               load_enc_c;
  cd_t               step_c;
  logic              two_c;

  p_box_64_56 u_pc1 (.din(key_in), .dout(pc1_c));
  p_box_56_48 u_pc2 (.din(cd),     .dout(round_key));

  assign key_ready  = (state == IDLE);
  assign rk_valid   = (state == RUN);
  assign last_round = (state == RUN) && (round_idx == 4'd15);

  // Load values and next-round rotation derived from the current registers
  always_comb begin
    load_raw_c   = cd_t'(pc1_c);
    load_enc_c.c = rot_half(load_raw_c.c, 1'b1, shift_two(4'd0));
    load_enc_c.d = rot_half(load_raw_c.d, 1'b1, shift_two(4'd0));
    two_c        = mode ? shift_two(IDX_W'(4'd15 - round_idx))
                        : shift_two(IDX_W'(round_idx + 4'd1));
    step_c.c     = rot_half(cd.c, !mode, two_c);
    step_c.d     = rot_half(cd.d, !mode, two_c);
  end

  // Sequencer state, C/D halves, round index and latched direction
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cd        <= '0;
      round_idx <= '0;
      mode      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (key_valid) begin
            mode      <= decrypt;
            round_idx <= '0;
            cd        <= decrypt ? load_raw_c : load_enc_c;
            state     <= RUN;
          end
        end
        RUN: begin
          if (rk_ready) begin
            if (round_idx == 4'd15) begin
              state     <= IDLE;
              round_idx <= '0;
              if (CLEAR_ON_DONE) cd <= '0;
            end else begin
              cd        <= step_c;
              round_idx <= round_idx + 4'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_des_key_schedule_seq.sv
// Directed bench for the DES key-schedule sequencer with a table-driven reference model.
module tb_des_key_schedule_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        key_valid;
  logic        key_ready;
  logic [63:0] key_in;
  logic        decrypt;
  logic        rk_valid;
  logic        rk_ready;
  logic [47:0] round_key;
  logic [3:0]  round_idx;
  logic        last_round;

  int vectors = 0;
  int errs    = 0;

  logic [47:0] exp_rk [16];
  logic [47:0] obs_rk [16];

  localparam logic [63:0] KEY_A = 64'h133457799BBCDFF1;

  int M_PC1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};
  int M_PC2 [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
  int M_SH [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  des_key_schedule_seq #(.CLEAR_ON_DONE(1'b1)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .key_valid  (key_valid),
    .key_ready  (key_ready),
    .key_in     (key_in),
    .decrypt    (decrypt),
    .rk_valid   (rk_valid),
    .rk_ready   (rk_ready),
    .round_key  (round_key),
    .round_idx  (round_idx),
    .last_round (last_round)
  );

  always #5 clk = ~clk;

  // Encrypt-order round key r, using 1-based DES bit arrays and cumulative rotation
  function automatic logic [47:0] model_rk(input logic [63:0] key, input int r);
    logic b [1:64];
    logic cd0 [1:56];
    logic cdr [1:56];
    logic [47:0] k;
    int tot;
    for (int i = 1; i <= 64; i++) b[i] = key[64 - i];
    for (int i = 1; i <= 56; i++) cd0[i] = b[M_PC1[i-1]];
    tot = 0;
    for (int j = 0; j <= r; j++) tot += M_SH[j];
    for (int p = 1; p <= 28; p++) begin
      cdr[p]      = cd0[((p - 1 + tot) % 28) + 1];
      cdr[p + 28] = cd0[((p - 1 + tot) % 28) + 29];
    end
    for (int i = 1; i <= 48; i++) k[48 - i] = cdr[M_PC2[i-1]];
    return k;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic build_exp(input logic [63:0] key);
    for (int r = 0; r < 16; r++) exp_rk[r] = model_rk(key, r);
  endtask

  // Accept one key then drain all 16 round keys; optional stalls and key_valid pokes
  task automatic run_key(input logic [63:0] key, input bit dec, input bit stall, input bit poke);
    int n;
    int cyc;
    bit rdy;
    check("key_ready_before_accept", 64'(key_ready), 64'd1);
    key_in    = key;
    decrypt   = dec;
    key_valid = 1'b1;
    rk_ready  = 1'b1;
    @(posedge clk); #1;
    key_valid = 1'b0;
    check("rk_valid_after_accept", 64'(rk_valid), 64'd1);
    n   = 0;
    cyc = 0;
    while (n < 16 && cyc < 200) begin
      rdy      = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      rk_ready = rdy;
      if (poke) begin
        key_valid = 1'($urandom_range(0, 1));
        key_in    = {$urandom, $urandom};
        decrypt   = 1'($urandom_range(0, 1));
      end
      check("rk_valid_run", 64'(rk_valid), 64'd1);
      check("key_ready_run", 64'(key_ready), 64'd0);
      check("round_idx", 64'(round_idx), 64'(n));
      check("round_key", 64'(round_key), 64'(dec ? exp_rk[15 - n] : exp_rk[n]));
      check("last_round", 64'(last_round), 64'(n == 15));
      obs_rk[n] = round_key;
      @(posedge clk); #1;
      if (rdy) n++;
      cyc++;
    end
    key_valid = 1'b0;
    rk_ready  = 1'b0;
    check("handshake_count", 64'(n), 64'd16);
    check("key_ready_after_done", 64'(key_ready), 64'd1);
    check("rk_valid_after_done", 64'(rk_valid), 64'd0);
    check("round_key_cleared", 64'(round_key), 64'd0);
    check("round_idx_after_done", 64'(round_idx), 64'd0);
    check("last_round_after_done", 64'(last_round), 64'd0);
  endtask

  initial begin
    rst_n     = 1'b0;
    key_valid = 1'b0;
    key_in    = '0;
    decrypt   = 1'b0;
    rk_ready  = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    check("reset_key_ready", 64'(key_ready), 64'd1);
    check("reset_rk_valid", 64'(rk_valid), 64'd0);
    check("reset_round_key", 64'(round_key), 64'd0);
    check("reset_round_idx", 64'(round_idx), 64'd0);
    check("reset_last_round", 64'(last_round), 64'd0);

    // Encrypt, unstalled, with hand-computed anchors
    build_exp(KEY_A);
    run_key(KEY_A, 1'b0, 1'b0, 1'b0);
    check("enc_k0", 64'(obs_rk[0]), 64'h1B02EFFC7072);
    check("enc_k1", 64'(obs_rk[1]), 64'h79AED9DBC9E5);
    check("enc_k15", 64'(obs_rk[15]), 64'hCB3D8B0E17F5);

    // Decrypt, same key: K16 first
    run_key(KEY_A, 1'b1, 1'b0, 1'b0);
    check("dec_k0", 64'(obs_rk[0]), 64'hCB3D8B0E17F5);
    check("dec_k14", 64'(obs_rk[14]), 64'h79AED9DBC9E5);
    check("dec_k15", 64'(obs_rk[15]), 64'h1B02EFFC7072);

    // Random downstream stalls
    run_key(KEY_A, 1'b0, 1'b1, 1'b0);
    run_key(KEY_A, 1'b1, 1'b1, 1'b0);

    // key_valid and key_in toggling while running
    run_key(KEY_A, 1'b0, 1'b1, 1'b1);

    // Parity bits flipped: same schedule
    run_key(KEY_A ^ 64'h0101010101010101, 1'b0, 1'b0, 1'b0);

    // Another key through the model
    build_exp(64'h0E329232EA6D0D73);
    run_key(64'h0E329232EA6D0D73, 1'b0, 1'b1, 1'b0);
    run_key(64'h0E329232EA6D0D73, 1'b1, 1'b0, 1'b0);

    // Asynchronous reset at round 7
    build_exp(KEY_A);
    key_in    = KEY_A;
    decrypt   = 1'b0;
    key_valid = 1'b1;
    rk_ready  = 1'b1;
    @(posedge clk); #1;
    key_valid = 1'b0;
    repeat (7) begin
      @(posedge clk); #1;
    end
    check("pre_abort_round_idx", 64'(round_idx), 64'd7);
    rk_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("abort_key_ready", 64'(key_ready), 64'd1);
    check("abort_rk_valid", 64'(rk_valid), 64'd0);
    check("abort_round_key", 64'(round_key), 64'd0);
    check("abort_round_idx", 64'(round_idx), 64'd0);
    check("abort_last_round", 64'(last_round), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_key(KEY_A, 1'b0, 1'b0, 1'b0);
    check("post_abort_k0", 64'(obs_rk[0]), 64'h1B02EFFC7072);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
